// File: rtl/updown_counter_param_if.sv
// updown_counter_param_if
//   Control/status bundle for updown_counter_param.
//   master: drives Clr, Load, Din, En, Mode; observes OUT, TC, Wrap, Sat.
//   slave : the counter itself.
//   WIDTH must match the WIDTH of the counter it is attached to.
interface updown_counter_param_if #(
  parameter int unsigned WIDTH = 4
);
  logic             Clr;
  logic             Load;
  logic [WIDTH-1:0] Din;
  logic             En;
  logic             Mode;
  logic [WIDTH-1:0] OUT;
  logic             TC;
  logic             Wrap;
  logic             Sat;

  modport master (
    output Clr, Load, Din, En, Mode,
    input  OUT, TC, Wrap, Sat
  );

  modport slave (
    input  Clr, Load, Din, En, Mode,
    output OUT, TC, Wrap, Sat
  );
endinterface

// File: rtl/updown_counter_param.sv
// updown_counter_param
//   Parametrised up/down counter, range 0..MAX_VAL, with synchronous clear,
//   parallel load (clamped to MAX_VAL), count enable and a wrap or saturate
//   policy at the bounds. Chain digits by feeding a higher digit's En from
//   the lower digit's (En & TC).
// Ports:
//   Clk  - system clock, rising edge
//   RST  - asynchronous active-high reset
//   bus  - slave side of updown_counter_param_if:
//          Clr/Load/Din/En/Mode in; OUT (count), TC (terminal count,
//          combinational), Wrap (one-cycle pulse after a bound crossing),
//          Sat (request blocked at a bound, SATURATE=1 only) out
module updown_counter_param #(
  parameter int unsigned      WIDTH    = 4,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter bit               SATURATE = 1'b0
) (
  input  logic                  Clk,
  input  logic                  RST,
  updown_counter_param_if.slave bus
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;
  logic             at_top;
  logic             at_bot;

  // ">=" so that an out-of-range value is still treated as the upper bound.
  assign at_top = (cnt_q >= MAX_VAL);
  assign at_bot = (cnt_q == '0);

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    sat_d  = 1'b0;
    if (bus.Clr) begin
      cnt_d = '0;
    end else if (bus.Load) begin
      cnt_d = (bus.Din > MAX_VAL) ? MAX_VAL : bus.Din;
    end else if (bus.En) begin
      if (!bus.Mode) begin
        if (at_top) begin
          if (SATURATE) begin
            // pull an out-of-range value back onto the bound
            cnt_d = MAX_VAL;
            sat_d = 1'b1;
          end else begin
            cnt_d  = '0;
            wrap_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        if (at_bot) begin
          if (SATURATE) begin
            sat_d = 1'b1;
          end else begin
            cnt_d  = MAX_VAL;
            wrap_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge RST) begin
    if (RST) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      sat_q  <= sat_d;
    end
  end

  assign bus.OUT  = cnt_q;
  assign bus.Wrap = wrap_q;
  assign bus.Sat  = sat_q;
  assign bus.TC   = bus.Mode ? (cnt_q == '0) : (cnt_q == MAX_VAL);

endmodule

// File: tb/tb_updown_counter_param.sv
module tb_updown_counter_param;

  logic       Clk = 1'b0;
  logic       RST = 1'b0;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [3:0] din = '0;
  logic       en = 1'b0;
  logic       mode = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  // three configurations driven by identical stimulus
  updown_counter_param_if #(.WIDTH(4)) bus0 ();
  updown_counter_param_if #(.WIDTH(4)) bus1 ();
  updown_counter_param_if #(.WIDTH(4)) bus2 ();

  assign bus0.Clr = clr;  assign bus1.Clr = clr;  assign bus2.Clr = clr;
  assign bus0.Load = load; assign bus1.Load = load; assign bus2.Load = load;
  assign bus0.Din = din;  assign bus1.Din = din;  assign bus2.Din = din;
  assign bus0.En = en;    assign bus1.En = en;    assign bus2.En = en;
  assign bus0.Mode = mode; assign bus1.Mode = mode; assign bus2.Mode = mode;

  updown_counter_param #(.WIDTH(4)) u0 (.Clk(Clk), .RST(RST), .bus(bus0));
  updown_counter_param #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0)) u1 (.Clk(Clk), .RST(RST), .bus(bus1));
  updown_counter_param #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b1)) u2 (.Clk(Clk), .RST(RST), .bus(bus2));

  // reference model: plain integer arithmetic on the counting rules
  int maxv[3] = '{15, 9, 9};
  int satp[3] = '{0, 0, 1};
  int m_cnt[3];
  int m_wrap[3];
  int m_sat[3];

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_wrap[i] = 0; m_sat[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      int c, w, s;
      c = m_cnt[i]; w = 0; s = 0;
      if (RST) c = 0;
      else if (clr) c = 0;
      else if (load) c = (int'(din) > maxv[i]) ? maxv[i] : int'(din);
      else if (en && !mode) begin
        if (c < maxv[i]) c = c + 1;
        else if (satp[i] != 0) begin c = maxv[i]; s = 1; end
        else begin c = 0; w = 1; end
      end else if (en && mode) begin
        if (c > 0) c = c - 1;
        else if (satp[i] != 0) s = 1;
        else begin c = maxv[i]; w = 1; end
      end
      m_cnt[i] = c; m_wrap[i] = w; m_sat[i] = s;
    end
  endtask

  function automatic int model_tc(int i);
    return mode ? int'(m_cnt[i] == 0) : int'(m_cnt[i] == maxv[i]);
  endfunction

  task automatic check_all(input string tag);
    int o[3], t[3], w[3], s[3];
    o[0] = int'(bus0.OUT); t[0] = int'(bus0.TC); w[0] = int'(bus0.Wrap); s[0] = int'(bus0.Sat);
    o[1] = int'(bus1.OUT); t[1] = int'(bus1.TC); w[1] = int'(bus1.Wrap); s[1] = int'(bus1.Sat);
    o[2] = int'(bus2.OUT); t[2] = int'(bus2.TC); w[2] = int'(bus2.Wrap); s[2] = int'(bus2.Sat);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("%s_d%0d_out", tag, i), o[i], m_cnt[i]);
      check_eq($sformatf("%s_d%0d_tc", tag, i), t[i], model_tc(i));
      check_eq($sformatf("%s_d%0d_wrap", tag, i), w[i], m_wrap[i]);
      check_eq($sformatf("%s_d%0d_sat", tag, i), s[i], m_sat[i]);
    end
  endtask

  // inputs are changed just after a falling edge; tick applies one rising edge
  task automatic tick(input string tag);
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
    check_all(tag);
  endtask

  task automatic set_in(input logic c, input logic l, input logic [3:0] d,
                        input logic e, input logic m);
    clr = c; load = l; din = d; en = e; mode = m;
  endtask

  initial begin
    model_reset();
    // reset pulse
    @(negedge Clk);
    RST = 1'b1;
    #1;
    check_all("rst");
    check_eq("rst_out0_const", int'(bus0.OUT), 0);
    tick("rst_hold");
    RST = 1'b0;

    // full up count, default config
    set_in(0, 0, 0, 1, 0);
    for (int i = 0; i < 16; i++) begin
      tick("up16");
      check_eq("up16_out0_const", int'(bus0.OUT), (i + 1) % 16);
    end
    check_eq("up16_wrap_after_15to0", int'(bus0.Wrap), 1);

    // full down count from 0
    set_in(1, 0, 0, 0, 0);
    tick("clr0");
    set_in(0, 0, 0, 1, 1);
    for (int i = 0; i < 16; i++) begin
      tick("dn16");
      check_eq("dn16_out0_const", int'(bus0.OUT), 15 - i);
    end

    // MAX_VAL=9 wrap/clamp sequence
    set_in(0, 1, 4'd7, 0, 0);
    tick("ld7");
    set_in(0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) tick("up4");
    check_eq("up4_out1_const", int'(bus1.OUT), 1);
    set_in(0, 1, 4'd12, 0, 0);
    tick("ld12");
    check_eq("ld12_clamp_out1", int'(bus1.OUT), 9);
    set_in(0, 0, 0, 1, 1);
    for (int i = 0; i < 10; i++) tick("dn10");
    check_eq("dn10_out1_const", int'(bus1.OUT), 9);

    // saturation at both bounds
    set_in(0, 1, 4'd8, 0, 0);
    tick("ld8");
    set_in(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) tick("satup");
    check_eq("satup_sat2_const", int'(bus2.Sat), 1);
    check_eq("satup_out2_const", int'(bus2.OUT), 9);
    set_in(0, 1, 4'd0, 0, 0);
    tick("ld0");
    set_in(0, 0, 0, 1, 1);
    tick("satdn");
    check_eq("satdn_out2_const", int'(bus2.OUT), 0);

    // priority
    set_in(0, 1, 4'd3, 0, 0);
    tick("ld3");
    set_in(1, 1, 4'd5, 1, 0);
    tick("prio_clr");
    check_eq("prio_clr_out0", int'(bus0.OUT), 0);
    set_in(0, 1, 4'd5, 1, 0);
    tick("prio_load");
    check_eq("prio_load_out0", int'(bus0.OUT), 5);
    set_in(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick("hold");

    // asynchronous reset mid-cycle
    set_in(0, 1, 4'd6, 0, 0);
    tick("ld6");
    set_in(0, 0, 0, 1, 0);
    #2;
    RST = 1'b1;
    #1;
    model_reset();
    check_all("async");
    check_eq("async_out0_const", int'(bus0.OUT), 0);
    for (int i = 0; i < 16; i++) tick("rst_en");
    RST = 1'b0;
    tick("rel");
    check_eq("rel_out0_const", int'(bus0.OUT), 1);

    // randomized run
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(63) == 0) begin
        RST = 1'b1;
        #1;
        model_reset();
        check_all("rnd_rst");
        tick("rnd_rsthold");
        RST = 1'b0;
      end
      set_in($urandom_range(15) == 0, $urandom_range(7) == 0, 4'($urandom_range(15)),
             $urandom_range(3) != 0, 1'($urandom_range(1)));
      tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
